ica_sample_buffer: RTL and testbench
====================================

// Module: ica_sample_buffer
// PURPOSE
//  Parametrised multi-channel sample store for whitened FastICA data (Z).
//  Captures one frame of NCH-channel samples and passes them straight through.
//  Replays the stored frame on demand, once per fixed-point iteration; replay
//  can be stalled with hold. Sits between the whitening stage and the
//  weight-update datapath. Tracks fill level and flags the end of each pass.
// PARAMETERS
//  NCH    4     number of channels (lanes)
//  DW     26    signed sample width per channel
//  DEPTH  128   samples per channel (frame length), >=2
//  AW     $clog2(DEPTH)  address width (derived, do not override)
// PORTS
//  clk       in   1        single clock, all logic on posedge
//  rst_n     in   1        asynchronous reset, active-low
//  en        in   1        block enable; low aborts any operation to IDLE
//  start     in   1        1-cycle request; honoured only in IDLE with en=1
//  wr_mode   in   1        sampled with start: 1=CAPTURE, 0=REPLAY
//  in_valid  in   1        CAPTURE: data_in holds a sample this cycle
//  data_in   in   NCH*DW   packed signed samples, ch0 in [DW-1:0]
//  hold      in   1        REPLAY stall: freezes address and outputs
//  q         out  NCH*DW   packed output samples, same lane order as data_in
//  q_valid   out  1        q carries a new sample this cycle
//  last      out  1        high with q_valid on the final sample of a capture/pass
//  full      out  1        DEPTH samples stored
//  n_stored  out  AW+1     samples held, 0..DEPTH
//  busy      out  1        state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, addr=0, q=0, q_valid=0, last=0, full=0,
//   n_stored=0, busy=0. Memory contents are not reset.
//  All outputs registered. q_valid and last pulse for 1 cycle per sample.
//  IDLE: on en & start:
//   - wr_mode=1 -> CAPTURE. Next edge: addr=0, n_stored=0, full=0.
//   - wr_mode=0 & n_stored!=0 -> REPLAY with addr=0.
//   - wr_mode=0 & n_stored==0 -> ignored, stay IDLE, no output.
//  CAPTURE: on a cycle with in_valid=1:
//   - mem[addr] <= data_in, q <= data_in, q_valid=1 next cycle (1-cycle latency).
//   - addr and n_stored both increment.
//   - When addr==DEPTH-1: last=1 on that sample, full=1, return to IDLE.
//   - Samples offered after that are dropped.
//  CAPTURE: on a cycle with in_valid=0: q holds, q_valid=0.
//  REPLAY: on a cycle with hold=0:
//   - q <= mem[addr] for all lanes; q_valid=1 next cycle.
//   - addr increments.
//   - At addr==n_stored-1: last=1, return to IDLE (exactly n_stored samples/pass).
//  REPLAY: on a cycle with hold=1: addr unchanged, q holds, q_valid=0.
//   - Replay resumes at the same address, so no sample is lost or repeated.
//  start while busy: ignored.
//  en=0, any state:
//   - State goes to IDLE and addr to 0 next edge; q_valid=0, last=0.
//   - n_stored keeps partially captured samples; the partial frame can be replayed.
//  Same-address read/write never occurs (CAPTURE and REPLAY are exclusive states).
//  A new CAPTURE overwrites from addr 0; stale entries above n_stored are unread.
//  Width: data stored and returned bit-exact, no sign extension or arithmetic.
// TESTING
//  T1:
//   - Stimulus: reset, then CAPTURE of 128 samples, lane k = (i<<2)+k, in_valid=1 every cycle.
//   - Expect: q equals input 1 cycle later; last on i=127; full=1; n_stored=128; busy falls.
//  T2:
//   - Stimulus: REPLAY after T1 with hold=0.
//   - Expect: 128 consecutive q_valid, first q 1 cycle after start is accepted;
//     lanes match T1; last on the 128th sample.
//  T3:
//   - Stimulus: REPLAY with hold=1 at samples 10 and 11 (2 cycles).
//   - Expect: q_valid low for 2 cycles, q frozen at sample 9;
//     sample 10 follows; 128 samples total.
//  T4:
//   - Stimulus: CAPTURE of 50 samples with in_valid gaps, then en=0.
//   - Expect: n_stored=50, full=0, IDLE.
//   - Then REPLAY: exactly 50 samples, last on #50.
//  T5:
//   - Stimulus: REPLAY start with n_stored=0.
//   - Expect: ignored, busy stays 0.
//   - Stimulus: start pulsed mid-REPLAY.
//   - Expect: no restart.
//  T6:
//   - Stimulus: rst_n low mid-CAPTURE at sample 30, asynchronous to clk.
//   - Expect: all outputs 0 immediately; a subsequent REPLAY start is ignored.

Source files
------------

// File: rtl/ica_sample_buffer.sv
// Multi-channel frame store for whitened ICA samples.
// Captures a frame with pass-through, then replays it on demand with stall support.
module ica_sample_buffer #(
  parameter int NCH   = 4,
  parameter int DW    = 26,
  parameter int DEPTH = 128,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              start,
  input  logic              wr_mode,
  input  logic              in_valid,
  input  logic [NCH*DW-1:0] data_in,
  input  logic              hold,
  output logic [NCH*DW-1:0] q,
  output logic              q_valid,
  output logic              last,
  output logic              full,
  output logic [AW:0]       n_stored,
  output logic              busy
);

  // state     | meaning
  // S_IDLE    | waiting for start
  // S_CAPTURE | writing incoming samples to memory, passing them through
  // S_REPLAY  | reading back n_stored samples, stalled by hold
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CAPTURE = 2'd1;
  localparam logic [1:0] S_REPLAY  = 2'd2;

  localparam int W = NCH * DW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [1:0]    state;
  logic [AW-1:0] addr;
  logic [W-1:0]  mem [DEPTH];
  logic          wr_en;
  logic          replay_end;

  assign wr_en      = en && (state == S_CAPTURE) && in_valid;
  assign replay_end = ({1'b0, addr} == (n_stored - (AW+1)'(1)));
  assign busy       = (state != S_IDLE);

  // Storage carries no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      addr     <= '0;
      q        <= '0;
      q_valid  <= 1'b0;
      last     <= 1'b0;
      full     <= 1'b0;
      n_stored <= '0;
    end else begin
      q_valid <= 1'b0;
      last    <= 1'b0;
      if (!en) begin
        // Abort keeps n_stored so a partial frame can still be replayed.
        state <= S_IDLE;
        addr  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (wr_mode) begin
                state    <= S_CAPTURE;
                addr     <= '0;
                n_stored <= '0;
                full     <= 1'b0;
              end else if (n_stored != '0) begin
                state <= S_REPLAY;
                addr  <= '0;
              end
            end
          end
          S_CAPTURE: begin
            if (in_valid) begin
              q        <= data_in;
              q_valid  <= 1'b1;
              n_stored <= n_stored + (AW+1)'(1);
              if (addr == LAST_ADDR) begin
                last  <= 1'b1;
                full  <= 1'b1;
                state <= S_IDLE;
                addr  <= '0;
              end else begin
                addr <= addr + AW'(1);
              end
            end
          end
          S_REPLAY: begin
            if (!hold) begin
              q       <= mem[addr];
              q_valid <= 1'b1;
              if (replay_end) begin
                last  <= 1'b1;
                state <= S_IDLE;
                addr  <= '0;
              end else begin
                addr <= addr + AW'(1);
              end
            end
          end
          default: begin
            state <= S_IDLE;
            addr  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ica_sample_buffer.sv
// Self-checking bench for ica_sample_buffer: frame-level reference model,
// per-cycle output compare, and literal checks on captured/replayed frames.
module tb_ica_sample_buffer;
  localparam int NCH   = 4;
  localparam int DW    = 26;
  localparam int DEPTH = 128;
  localparam int AW    = $clog2(DEPTH);
  localparam int W     = NCH * DW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en, start, wr_mode, in_valid, hold;
  logic [W-1:0]  data_in;
  logic [W-1:0]  q;
  logic          q_valid, last, full, busy;
  logic [AW:0]   n_stored;

  always #5 clk = ~clk;

  ica_sample_buffer #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .wr_mode(wr_mode),
    .in_valid(in_valid), .data_in(data_in), .hold(hold), .q(q),
    .q_valid(q_valid), .last(last), .full(full), .n_stored(n_stored), .busy(busy)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame contents plus a read/write pointer and activity mode
  int           m_mode = 0;   // 0 none, 1 filling, 2 playing back
  int           m_ptr  = 0;
  int           m_cnt  = 0;
  bit           m_full = 0, m_qv = 0, m_last = 0;
  logic [W-1:0] m_q    = '0;
  logic [W-1:0] m_frame [DEPTH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_ptr = 0; m_cnt = 0; m_full = 0; m_qv = 0; m_last = 0; m_q = '0;
    end else begin
      m_qv = 0; m_last = 0;
      if (!en) begin
        m_mode = 0; m_ptr = 0;
      end else if (m_mode == 0) begin
        if (start && wr_mode) begin
          m_mode = 1; m_ptr = 0; m_cnt = 0; m_full = 0;
        end else if (start && m_cnt > 0) begin
          m_mode = 2; m_ptr = 0;
        end
      end else if (m_mode == 1) begin
        if (in_valid) begin
          m_frame[m_ptr] = data_in;
          m_q = data_in; m_qv = 1;
          m_ptr++; m_cnt++;
          if (m_cnt == DEPTH) begin
            m_last = 1; m_full = 1; m_mode = 0; m_ptr = 0;
          end
        end
      end else begin
        if (!hold) begin
          m_q = m_frame[m_ptr]; m_qv = 1;
          m_ptr++;
          if (m_ptr == m_cnt) begin
            m_last = 1; m_mode = 0; m_ptr = 0;
          end
        end
      end
    end
  end

  logic [W-1:0] obs_q [$];
  bit           obs_last [$];

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("q_valid", q_valid, m_qv);
      cmp("last", last, m_last);
      cmp("q", q, m_q);
      cmp("full", full, m_full);
      cmp("n_stored", n_stored, 128'(m_cnt));
      cmp("busy", busy, m_mode != 0);
      if (q_valid) begin
        obs_q.push_back(q);
        obs_last.push_back(last);
      end
    end
  end

  logic [W-1:0] exp_frame [DEPTH];

  function automatic logic [W-1:0] pat(input int i);
    logic [W-1:0] p;
    p = '0;
    for (int k = 0; k < NCH; k++) p[k*DW +: DW] = DW'((i << 2) + k);
    return p;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input bit wm);
    start = 1'b1; wr_mode = wm;
    step();
    start = 1'b0; wr_mode = 1'b0;
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_last.delete();
  endtask

  task automatic check_frame(input string name, input int n);
    cmp({name, "_count"}, obs_q.size(), n);
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      cmp({name, "_data"}, obs_q[i], exp_frame[i]);
      cmp({name, "_last"}, obs_last[i], i == n - 1);
    end
  endtask

  // style: 0 no stall, 1 stall at samples 10..11, 2 random stall plus a start pulse while busy
  task automatic replay_run(input string name, input int n, input int style);
    int c;
    clear_obs();
    pulse_start(1'b0);
    c = 0;
    while (obs_q.size() < n && c < 600) begin
      c++;
      case (style)
        1:       hold = (c == 11 || c == 12);
        2:       hold = ($urandom_range(0, 3) == 0);
        default: hold = 1'b0;
      endcase
      start   = (style == 2 && c == 20);
      wr_mode = (style == 2 && c == 20);
      step();
    end
    hold = 1'b0; start = 1'b0; wr_mode = 1'b0;
    repeat (4) step();
    if (c >= 600) cmp({name, "_timeout"}, obs_q.size(), n);
    check_frame(name, n);
    cmp({name, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    int acc, c;
    rst_n = 1'b0; en = 1'b0; start = 1'b0; wr_mode = 1'b0;
    in_valid = 1'b0; hold = 1'b0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b1;
    cmp("rst_q", q, 0);
    cmp("rst_q_valid", q_valid, 0);
    cmp("rst_n_stored", n_stored, 0);
    cmp("rst_full", full, 0);
    cmp("rst_busy", busy, 0);
    rst_n = 1'b1; en = 1'b1;
    step();

    // replay request with nothing stored
    clear_obs();
    pulse_start(1'b0);
    repeat (3) step();
    cmp("empty_replay_busy", busy, 0);
    cmp("empty_replay_out", obs_q.size(), 0);

    // full capture, two extra samples offered after the frame fills
    clear_obs();
    pulse_start(1'b1);
    for (int i = 0; i < DEPTH + 2; i++) begin
      in_valid = 1'b1; data_in = pat(i);
      step();
    end
    in_valid = 1'b0;
    step();
    for (int i = 0; i < DEPTH; i++) exp_frame[i] = pat(i);
    check_frame("capture", DEPTH);
    cmp("capture_full", full, 1);
    cmp("capture_n_stored", n_stored, 128);
    cmp("capture_busy", busy, 0);
    cmp("capture_lane3_s127", obs_q[DEPTH-1][3*DW +: DW], 26'd511);

    replay_run("replay", DEPTH, 0);
    replay_run("replay_hold", DEPTH, 1);

    // partial capture with gaps, aborted by en
    clear_obs();
    pulse_start(1'b1);
    acc = 0; c = 0;
    while (acc < 50 && c < 500) begin
      c++;
      in_valid = ($urandom_range(0, 2) != 0);
      data_in  = rnd();
      if (in_valid) begin
        exp_frame[acc] = data_in;
        acc++;
      end
      step();
    end
    in_valid = 1'b0; en = 1'b0;
    step();
    en = 1'b1;
    step();
    cmp("partial_n_stored", n_stored, 50);
    cmp("partial_full", full, 0);
    cmp("partial_busy", busy, 0);
    replay_run("partial_replay", 50, 2);

    // asynchronous reset in the middle of a capture
    pulse_start(1'b1);
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1; data_in = rnd();
      step();
    end
    in_valid = 1'b1; data_in = rnd();
    #2;
    rst_n = 1'b0;
    #1;
    cmp("async_q", q, 0);
    cmp("async_q_valid", q_valid, 0);
    cmp("async_last", last, 0);
    cmp("async_full", full, 0);
    cmp("async_n_stored", n_stored, 0);
    cmp("async_busy", busy, 0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    clear_obs();
    pulse_start(1'b0);
    repeat (4) step();
    cmp("post_rst_replay_busy", busy, 0);
    cmp("post_rst_replay_out", obs_q.size(), 0);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
